// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the SRAM-like bridge: channel FSM state encoding and
// bus transfer-size codes.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } chan_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_chan.sv
// One SRAM-like channel: turns a held single-cycle access into a req/addr_ok
// handshake followed by a data_ok response, raises stall until the response
// arrives and keeps the returned word until the pipeline advances.
// Optional feature macro: BRIDGE_PERF_CNT_EN (adds a stall-cycle counter).
module sram_like_chan
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  input  logic        longest_stall_i,
  output logic        req_o,
  output logic        wr_o,
  output logic [1:0]  size_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        addr_ok_i,
  input  logic        data_ok_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o
`ifdef BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] wait_cnt_o
`endif
);

  chan_state_e state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] saved_q, saved_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        new_req;

  // A fresh request may only start from IDLE and never during a flush.
  assign new_req = (state_q == ST_IDLE) && en_i && !flush_i;

  // State, request latches, discard flag and saved read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      saved_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      saved_q   <= saved_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
    end
  end

  // Next state and register updates; the only consumer of longest_stall_i.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    saved_d   = saved_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    wr_d      = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (new_req) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          size_d  = size_i;
          wr_d    = wr_i;
          state_d = addr_ok_i ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flush_i)   discard_d = 1'b1;
        if (addr_ok_i) state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (data_ok_i) begin
          // A flushed transaction's response is dropped and never parks in HOLD.
          if (!(discard_q || flush_i)) saved_d = rdata_i;
          discard_d = 1'b0;
          state_d   = (discard_q || flush_i || !longest_stall_i) ? ST_IDLE : ST_HOLD;
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!longest_stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus fields, stall and read data; kept apart from the next-state logic so a
  // longest_stall_i derived from stall_o forms no combinational loop.
  always_comb begin
    req_o   = 1'b0;
    wr_o    = wr_q;
    size_o  = size_q;
    addr_o  = addr_q;
    wdata_o = wdata_q;
    stall_o = 1'b0;
    rdata_o = saved_q;
    case (state_q)
      ST_IDLE: begin
        if (new_req) begin
          req_o   = 1'b1;
          wr_o    = wr_i;
          size_o  = size_i;
          addr_o  = addr_i;
          wdata_o = wdata_i;
          stall_o = 1'b1;
        end
      end
      ST_ADDR: begin
        req_o   = 1'b1;
        stall_o = 1'b1;
      end
      ST_DATA: begin
        rdata_o = rdata_i;
        stall_o = !data_ok_i;
      end
      default: ;
    endcase
  end

`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] wait_cnt_q;

  // Wrapping count of cycles spent stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_q + 32'(stall_o);
  end

  assign wait_cnt_o = wait_cnt_q;
`endif

endmodule

// File: rtl/sram_like_bridge.sv
// Pipeline-to-SRAM-like bridge: one independent channel for instruction fetch
// and one for M-stage data accesses. The top only fixes per-channel wr/size/wdata.
// Optional feature macro: BRIDGE_PERF_CNT_EN (per-channel stall-cycle counters).
module sram_like_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_stall_o,
  input  logic        data_en_i,
  input  logic [3:0]  data_wen_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_stall_o,
  input  logic        longest_stall_i,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic        inst_wr_o,
  output logic [1:0]  inst_size_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_wdata_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i
`ifdef BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] inst_wait_cnt_o,
  output logic [31:0] data_wait_cnt_o
`endif
);

  // Fetches are always full-word reads.
  sram_like_chan u_inst (
    .clk             (clk),
    .rst             (rst),
    .en_i            (inst_en_i),
    .wr_i            (1'b0),
    .size_i          (SIZE_WORD),
    .addr_i          (inst_addr_i),
    .wdata_i         (32'd0),
    .flush_i         (flush_i),
    .longest_stall_i (longest_stall_i),
    .req_o           (inst_req_o),
    .wr_o            (inst_wr_o),
    .size_o          (inst_size_o),
    .addr_o          (inst_addr_o),
    .wdata_o         (inst_wdata_o),
    .addr_ok_i       (inst_addr_ok_i),
    .data_ok_i       (inst_data_ok_i),
    .rdata_i         (inst_rdata_i),
    .rdata_o         (inst_rdata_o),
    .stall_o         (inst_stall_o)
`ifdef BRIDGE_PERF_CNT_EN
    ,
    .wait_cnt_o      (inst_wait_cnt_o)
`endif
  );

  // Any asserted byte enable marks the access as a store.
  sram_like_chan u_data (
    .clk             (clk),
    .rst             (rst),
    .en_i            (data_en_i),
    .wr_i            (|data_wen_i),
    .size_i          (data_size_i),
    .addr_i          (data_addr_i),
    .wdata_i         (data_wdata_i),
    .flush_i         (flush_i),
    .longest_stall_i (longest_stall_i),
    .req_o           (data_req_o),
    .wr_o            (data_wr_o),
    .size_o          (data_size_o),
    .addr_o          (data_addr_o),
    .wdata_o         (data_wdata_o),
    .addr_ok_i       (data_addr_ok_i),
    .data_ok_i       (data_data_ok_i),
    .rdata_i         (data_rdata_i),
    .rdata_o         (data_rdata_o),
    .stall_o         (data_stall_o)
`ifdef BRIDGE_PERF_CNT_EN
    ,
    .wait_cnt_o      (data_wait_cnt_o)
`endif
  );

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge. Reference behaviour is expressed per
// transaction: stall cycles = 1 + addr waits + data waits, request cycles =
// 1 + addr waits, fields seen at the handshake equal the issued access, read
// data equals the slave's response and is held until the pipeline advances.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_stall_o;
  logic        data_en_i;
  logic [3:0]  data_wen_i;
  logic [1:0]  data_size_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_stall_o;
  logic        longest_stall;
  logic        flush_i;
  logic        inst_req_o, inst_wr_o;
  logic [1:0]  inst_size_o;
  logic [31:0] inst_addr_o, inst_wdata_o;
  logic        inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic        ext_stall;
`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] inst_wait_cnt_o, data_wait_cnt_o;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          cycles = 0;
  logic [31:0] exp_inst_saved;

  // Global stall as the hazard unit would form it.
  assign longest_stall = inst_stall_o | data_stall_o | ext_stall;

  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  sram_like_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_en_i       (inst_en_i),
    .inst_addr_i     (inst_addr_i),
    .inst_rdata_o    (inst_rdata_o),
    .inst_stall_o    (inst_stall_o),
    .data_en_i       (data_en_i),
    .data_wen_i      (data_wen_i),
    .data_size_i     (data_size_i),
    .data_addr_i     (data_addr_i),
    .data_wdata_i    (data_wdata_i),
    .data_rdata_o    (data_rdata_o),
    .data_stall_o    (data_stall_o),
    .longest_stall_i (longest_stall),
    .flush_i         (flush_i),
    .inst_req_o      (inst_req_o),
    .inst_wr_o       (inst_wr_o),
    .inst_size_o     (inst_size_o),
    .inst_addr_o     (inst_addr_o),
    .inst_wdata_o    (inst_wdata_o),
    .inst_addr_ok_i  (inst_addr_ok_i),
    .inst_data_ok_i  (inst_data_ok_i),
    .inst_rdata_i    (inst_rdata_i),
    .data_req_o      (data_req_o),
    .data_wr_o       (data_wr_o),
    .data_size_o     (data_size_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_addr_ok_i  (data_addr_ok_i),
    .data_data_ok_i  (data_data_ok_i),
    .data_rdata_i    (data_rdata_i)
`ifdef BRIDGE_PERF_CNT_EN
    ,
    .inst_wait_cnt_o (inst_wait_cnt_o),
    .data_wait_cnt_o (data_wait_cnt_o)
`endif
  );

  // One fetch with a addr_ok wait cycles and d data_ok wait cycles; en stays high.
  task automatic run_fetch(input int a, input int d, input logic [31:0] pc,
                           input logic [31:0] rd, output int stalls, output int reqs);
    stalls = 0;
    reqs   = 0;
    for (int i = 0; i <= a; i++) begin
      inst_en_i = 1'b1; inst_addr_i = pc; flush_i = 1'b0;
      inst_addr_ok_i = (i == a); inst_data_ok_i = 1'b0; inst_rdata_i = $urandom;
      #1;
      stalls += int'(inst_stall_o);
      reqs   += int'(inst_req_o);
      if (i == a) begin
        vectors++;
        if (inst_addr_o !== pc) begin
          miscompares++; $display("FAIL fetch_addr got %h want %h", inst_addr_o, pc);
        end
        vectors++;
        if ({inst_wr_o, inst_size_o, inst_wdata_o} !== {1'b0, 2'd2, 32'd0}) begin
          miscompares++;
          $display("FAIL fetch_fields got wr=%0b size=%0d wdata=%h want wr=0 size=2 wdata=0",
                   inst_wr_o, inst_size_o, inst_wdata_o);
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j <= d; j++) begin
      inst_addr_ok_i = 1'b0; inst_data_ok_i = (j == d);
      inst_rdata_i = (j == d) ? rd : $urandom;
      #1;
      stalls += int'(inst_stall_o);
      reqs   += int'(inst_req_o);
      if (j == d) begin
        vectors++;
        if (inst_rdata_o !== rd) begin
          miscompares++; $display("FAIL fetch_rdata got %h want %h", inst_rdata_o, rd);
        end
      end
      @(negedge clk);
    end
    inst_data_ok_i = 1'b0;
    exp_inst_saved = rd;
  endtask

  // One random data access with a/d wait cycles and h cycles parked in HOLD.
  task automatic run_data_txn(input int a, input int d, input int h);
    logic [31:0] ad, wd, rd;
    logic [3:0]  wen;
    logic [1:0]  sz;
    int          stalls, reqs;
    ad = $urandom; wd = $urandom; rd = $urandom;
    wen = 4'($urandom); sz = 2'($urandom_range(0, 2));
    stalls = 0; reqs = 0;
    for (int i = 0; i <= a; i++) begin
      data_en_i = 1'b1; data_wen_i = wen; data_size_i = sz; data_addr_i = ad; data_wdata_i = wd;
      data_addr_ok_i = (i == a); data_data_ok_i = 1'($urandom); data_rdata_i = $urandom;
      #1;
      stalls += int'(data_stall_o);
      reqs   += int'(data_req_o);
      if (i == a) begin
        vectors++;
        if ({data_wr_o, data_size_o, data_addr_o, data_wdata_o} !== {|wen, sz, ad, wd}) begin
          miscompares++;
          $display("FAIL rnd_fields got %0b/%0d/%h/%h want %0b/%0d/%h/%h", data_wr_o,
                   data_size_o, data_addr_o, data_wdata_o, |wen, sz, ad, wd);
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j <= d; j++) begin
      data_addr_ok_i = 1'($urandom); data_data_ok_i = (j == d);
      data_rdata_i = (j == d) ? rd : $urandom;
      ext_stall = (j == d) ? (h > 0) : 1'($urandom);
      #1;
      stalls += int'(data_stall_o);
      reqs   += int'(data_req_o);
      if (j == d) begin
        vectors++;
        if (data_rdata_o !== rd) begin
          miscompares++; $display("FAIL rnd_rdata got %h want %h", data_rdata_o, rd);
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < h; k++) begin
      data_addr_ok_i = 1'($urandom); data_data_ok_i = 1'($urandom); data_rdata_i = $urandom;
      ext_stall = (k < h - 1);
      #1;
      vectors++;
      if ({data_req_o, data_stall_o, data_rdata_o} !== {2'b00, rd}) begin
        miscompares++;
        $display("FAIL rnd_hold got req=%0b stall=%0b rdata=%h want req=0 stall=0 rdata=%h",
                 data_req_o, data_stall_o, data_rdata_o, rd);
      end
      @(negedge clk);
    end
    data_en_i = 1'b0; data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; ext_stall = 1'b0;
    #1;
    vectors++;
    if ({data_req_o, data_stall_o, data_rdata_o} !== {2'b00, rd}) begin
      miscompares++;
      $display("FAIL rnd_idle got req=%0b stall=%0b rdata=%h want req=0 stall=0 rdata=%h",
               data_req_o, data_stall_o, data_rdata_o, rd);
    end
    vectors++;
    if (stalls !== 1 + a + d) begin
      miscompares++; $display("FAIL rnd_stall_cycles got %0d want %0d", stalls, 1 + a + d);
    end
    vectors++;
    if (reqs !== 1 + a) begin
      miscompares++; $display("FAIL rnd_req_cycles got %0d want %0d", reqs, 1 + a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({inst_req_o, inst_wr_o, inst_stall_o, data_req_o, data_wr_o, data_stall_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_ctrl got %b want 000000",
               {inst_req_o, inst_wr_o, inst_stall_o, data_req_o, data_wr_o, data_stall_o});
    end
    vectors++;
    if ({inst_size_o, data_size_o, inst_addr_o, data_addr_o} !== 68'd0) begin
      miscompares++;
      $display("FAIL rst_size_addr got %h %h %h %h want 0", inst_size_o, data_size_o,
               inst_addr_o, data_addr_o);
    end
    vectors++;
    if ({inst_wdata_o, data_wdata_o, inst_rdata_o, data_rdata_o} !== 128'd0) begin
      miscompares++;
      $display("FAIL rst_data got %h %h %h %h want 0", inst_wdata_o, data_wdata_o,
               inst_rdata_o, data_rdata_o);
    end
`ifdef BRIDGE_PERF_CNT_EN
    vectors++;
    if ({inst_wait_cnt_o, data_wait_cnt_o} !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_cnt got %h %h want 0", inst_wait_cnt_o, data_wait_cnt_o);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Asynchronous reset in the middle of a pending data request.
    data_en_i = 1'b1; data_wen_i = 4'hf; data_size_i = 2'd2;
    data_addr_i = 32'h8000_1000; data_wdata_i = $urandom;
    #1;
    vectors++;
    if (data_req_o !== 1'b1) begin
      miscompares++; $display("FAIL arst_req0 got %0b want 1", data_req_o);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (data_req_o !== 1'b1) begin
      miscompares++; $display("FAIL arst_req1 got %0b want 1", data_req_o);
    end
    rst = 1'b1; data_en_i = 1'b0;
    #1;
    vectors++;
    if ({data_req_o, data_stall_o, data_addr_o} !== 34'd0) begin
      miscompares++;
      $display("FAIL arst_abort got req=%0b stall=%0b addr=%h want 0", data_req_o,
               data_stall_o, data_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_inst_saved = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_fetch;
    int s, r;
    run_fetch(0, 0, 32'hBFC0_0000, 32'h3C08_0001, s, r);
    vectors++;
    if (s !== 1) begin miscompares++; $display("FAIL zw_stall_cycles got %0d want 1", s); end
    vectors++;
    if (r !== 1) begin miscompares++; $display("FAIL zw_req_cycles got %0d want 1", r); end
    inst_en_i = 1'b0; inst_rdata_i = $urandom;
    #1;
    vectors++;
    if ({inst_req_o, inst_stall_o, inst_rdata_o} !== {2'b00, 32'h3C08_0001}) begin
      miscompares++;
      $display("FAIL zw_after got req=%0b stall=%0b rdata=%h want 0 0 3c080001",
               inst_req_o, inst_stall_o, inst_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_store;
    logic [31:0] wd, rd;
    wd = $urandom; rd = $urandom;
    data_en_i = 1'b1; data_wen_i = 4'b0011; data_size_i = 2'd1;
    data_addr_i = 32'h8000_0004; data_wdata_i = wd;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok_i = (i == 3);
      #1;
      vectors++;
      if ({data_req_o, data_stall_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o} !==
          {3'b111, 2'd1, 32'h8000_0004, wd}) begin
        miscompares++;
        $display("FAIL st_req_c%0d got req=%0b stall=%0b wr=%0b size=%0d addr=%h wdata=%h want 1 1 1 1 80000004 %h",
                 i, data_req_o, data_stall_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, wd);
      end
      @(negedge clk);
      // Upstream inputs change while the request waits; the bus must not.
      data_addr_i = $urandom; data_wdata_i = $urandom; data_size_i = 2'd0; data_wen_i = 4'd0;
    end
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
    #1;
    vectors++;
    if ({data_req_o, data_stall_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL st_dwait got req=%0b stall=%0b want 0 1", data_req_o, data_stall_o);
    end
    @(negedge clk);
    data_data_ok_i = 1'b1; data_rdata_i = rd;
    #1;
    vectors++;
    if ({data_req_o, data_stall_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL st_done got req=%0b stall=%0b want 0 0", data_req_o, data_stall_o);
    end
    @(negedge clk);
    data_en_i = 1'b0; data_data_ok_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_hold;
    logic [31:0] r2;
    r2 = $urandom;
    data_en_i = 1'b1; data_wen_i = 4'd0; data_size_i = 2'd2;
    data_addr_i = $urandom & 32'hFFFF_FFFC; data_addr_ok_i = 1'b1;
    #1;
    vectors++;
    if (data_req_o !== 1'b1) begin miscompares++; $display("FAIL ld_req got %0b want 1", data_req_o); end
    @(negedge clk);
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h1234_5678; ext_stall = 1'b1;
    #1;
    vectors++;
    if ({data_stall_o, data_rdata_o} !== {1'b0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL ld_done got stall=%0b rdata=%h want 0 12345678", data_stall_o, data_rdata_o);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      data_data_ok_i = 1'b0; data_rdata_i = $urandom; ext_stall = (k == 0);
      #1;
      vectors++;
      if ({data_req_o, data_stall_o, data_rdata_o} !== {2'b00, 32'h1234_5678}) begin
        miscompares++;
        $display("FAIL ld_hold%0d got req=%0b stall=%0b rdata=%h want 0 0 12345678",
                 k, data_req_o, data_stall_o, data_rdata_o);
      end
      @(negedge clk);
    end
    ext_stall = 1'b0; data_addr_i = $urandom & 32'hFFFF_FFFC; data_addr_ok_i = 1'b1;
    #1;
    vectors++;
    if (data_req_o !== 1'b1) begin
      miscompares++; $display("FAIL ld_next_req got %0b want 1", data_req_o);
    end
    @(negedge clk);
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = r2;
    #1;
    vectors++;
    if (data_rdata_o !== r2) begin
      miscompares++; $display("FAIL ld_next_rdata got %h want %h", data_rdata_o, r2);
    end
    @(negedge clk);
    data_en_i = 1'b0; data_data_ok_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_fetch;
    logic [31:0] r;
    r = $urandom;
    inst_en_i = 1'b1; inst_addr_i = 32'hBFC0_0100; inst_addr_ok_i = 1'b1;
    #1;
    vectors++;
    if (inst_req_o !== 1'b1) begin miscompares++; $display("FAIL fl_req got %0b want 1", inst_req_o); end
    @(negedge clk);
    inst_addr_ok_i = 1'b0; flush_i = 1'b1; inst_addr_i = 32'hBFC0_0380;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if ({inst_req_o, inst_stall_o} !== 2'b01) begin
        miscompares++;
        $display("FAIL fl_wait%0d got req=%0b stall=%0b want 0 1", k, inst_req_o, inst_stall_o);
      end
      @(negedge clk);
      flush_i = 1'b0;
    end
    inst_data_ok_i = 1'b1; inst_rdata_i = $urandom; ext_stall = 1'b1;
    #1;
    vectors++;
    if ({inst_req_o, inst_stall_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL fl_drop got req=%0b stall=%0b want 0 0", inst_req_o, inst_stall_o);
    end
    @(negedge clk);
    inst_data_ok_i = 1'b0; ext_stall = 1'b0; inst_addr_ok_i = 1'b1;
    #1;
    vectors++;
    if ({inst_req_o, inst_addr_o, inst_rdata_o} !== {1'b1, 32'hBFC0_0380, exp_inst_saved}) begin
      miscompares++;
      $display("FAIL fl_newpc got req=%0b addr=%h rdata=%h want 1 bfc00380 %h",
               inst_req_o, inst_addr_o, inst_rdata_o, exp_inst_saved);
    end
    @(negedge clk);
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = r;
    #1;
    vectors++;
    if ({inst_stall_o, inst_rdata_o} !== {1'b0, r}) begin
      miscompares++;
      $display("FAIL fl_newdata got stall=%0b rdata=%h want 0 %h", inst_stall_o, inst_rdata_o, r);
    end
    @(negedge clk);
    inst_en_i = 1'b0; inst_data_ok_i = 1'b0; exp_inst_saved = r;
    @(negedge clk);
  endtask

  task automatic test_flush_idle;
    int s, r;
    inst_en_i = 1'b1; inst_addr_i = 32'hBFC0_0200; flush_i = 1'b1;
    #1;
    vectors++;
    if ({inst_req_o, inst_stall_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL fi_supp got req=%0b stall=%0b want 0 0", inst_req_o, inst_stall_o);
    end
    @(negedge clk);
    run_fetch(0, 0, 32'hBFC0_0200, $urandom, s, r);
    vectors++;
    if (r !== 1) begin miscompares++; $display("FAIL fi_after_req got %0d want 1", r); end
    inst_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int s, r, c0;
    c0 = cycles;
    for (int k = 0; k < 4; k++) begin
      run_fetch(0, 0, 32'hBFC0_0000 + 32'(4 * k), $urandom, s, r);
      vectors++;
      if (s !== 1 || r !== 1) begin
        miscompares++; $display("FAIL b2b_%0d got stall=%0d req=%0d want 1 1", k, s, r);
      end
    end
    vectors++;
    if (cycles - c0 !== 8) begin
      miscompares++; $display("FAIL b2b_cycles got %0d want 8", cycles - c0);
    end
    inst_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int a, d, s, r;
    for (int n = 0; n < 24; n++) begin
      run_data_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    for (int n = 0; n < 12; n++) begin
      a = $urandom_range(0, 3); d = $urandom_range(0, 3);
      run_fetch(a, d, $urandom & 32'hFFFF_FFFC, $urandom, s, r);
      vectors++;
      if (s !== 1 + a + d || r !== 1 + a) begin
        miscompares++;
        $display("FAIL rnd_fetch got stall=%0d req=%0d want %0d %0d", s, r, 1 + a + d, 1 + a);
      end
      inst_en_i = 1'b0;
      @(negedge clk);
    end
  endtask

`ifdef BRIDGE_PERF_CNT_EN
  task automatic test_perf_cnt;
    logic [31:0] c0;
    int s, r;
    c0 = inst_wait_cnt_o;
    run_fetch(2, 1, 32'hBFC0_0400, $urandom, s, r);
    inst_en_i = 1'b0;
    #1;
    vectors++;
    if (inst_wait_cnt_o - c0 !== 32'd4) begin
      miscompares++; $display("FAIL perf_cnt got %0d want 4", inst_wait_cnt_o - c0);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; ext_stall = 1'b0; flush_i = 1'b0;
    inst_en_i = 1'b0; inst_addr_i = '0; inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    inst_rdata_i = '0;
    data_en_i = 1'b0; data_wen_i = '0; data_size_i = '0; data_addr_i = '0; data_wdata_i = '0;
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = '0;
    exp_inst_saved = '0;
    test_reset;
    test_zero_wait_fetch;
    test_store;
    test_load_hold;
    test_flush_fetch;
    test_flush_idle;
    test_back_to_back;
    test_random;
`ifdef BRIDGE_PERF_CNT_EN
    test_perf_cnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
